// File: rtl/bram_reg_responder_pkg.sv
// Shared types and helpers for the BRAM register responder.
// Holds the host FSM encoding, bus widths and the byte-merge helper.
package bram_reg_responder_pkg;

    localparam int DATA_W = 32;
    localparam int WE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Replace only the bytes of 'old_w' whose enable bit is set.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [WE_W-1:0]   we
    );
        logic [DATA_W-1:0] w_res;
        w_res = old_w;
        for (int b = 0; b < WE_W; b++) begin
            if (we[b]) begin
                w_res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return w_res;
    endfunction

endpackage

// File: rtl/bram_reg_responder_reg_file.sv
// DEPTH x 32 register array with one byte-masked write port.
// Ports: aclk/areset, i_we (byte enables, 0 = no write), i_addr (word
// index), i_wdata, o_rdata (current word at i_addr, i.e. the pre-write
// value, which the top registers to give read-first behaviour).
module bram_reg_responder_reg_file
    import bram_reg_responder_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [WE_W-1:0]          i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (|i_we) begin
            r_mem[i_addr] <= byte_merge(r_mem[i_addr], i_wdata, i_we);
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/bram_reg_responder.sv
// Memory-side responder for the gpio_reg_array BRAM port plus a host
// request/ack port. Ports: aclk/areset; BRAM_* initiator port with
// registered BRAM_rddata and BRAM_busy hold-off; host_req/we/addr/wdata
// in, host_rdata/host_ack out; err_collision sticky violation flag.
module bram_reg_responder
    import bram_reg_responder_pkg::*;
#(
    parameter int          DEPTH      = 32,
    parameter int          BRAM_WIDTH = 11,
    parameter logic [31:0] OOR_DATA   = 32'h0000_0000
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [BRAM_WIDTH-1:0]    BRAM_addr,
    input  logic                     BRAM_en,
    input  logic [WE_W-1:0]          BRAM_we,
    input  logic [DATA_W-1:0]        BRAM_wrdata,
    output logic [DATA_W-1:0]        BRAM_rddata,
    output logic                     BRAM_busy,
    input  logic                     host_req,
    input  logic [WE_W-1:0]          host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [DATA_W-1:0]        host_wdata,
    output logic [DATA_W-1:0]        host_rdata,
    output logic                     host_ack,
    output logic                     err_collision
);

    localparam int IW = $clog2(DEPTH);

    state_t            r_state;
    logic [DATA_W-1:0] r_bram_rddata;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_err;

    logic [IW-1:0]     w_bram_idx;
    logic              w_bram_oor;
    logic              w_host_sel;
    logic [IW-1:0]     w_rf_addr;
    logic [WE_W-1:0]   w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;
    logic [DATA_W-1:0] w_rf_rdata;

    assign w_bram_idx = BRAM_addr[IW+1:2];
    // Any address bit above the word-index field puts us out of range.
    assign w_bram_oor = (BRAM_addr >> (IW + 2)) != '0;

    // The host owns the array only on the ACCESS edge; in every other
    // state the BRAM side drives it, so DRAIN accesses still land.
    assign w_host_sel = (r_state == ST_ACCESS);
    assign w_rf_addr  = w_host_sel ? host_addr : w_bram_idx;
    assign w_rf_wdata = w_host_sel ? host_wdata : BRAM_wrdata;

    always_comb begin
        w_rf_we = '0;
        if (w_host_sel) begin
            w_rf_we = host_we;
        end else if (BRAM_en && !w_bram_oor) begin
            w_rf_we = BRAM_we;
        end
    end

    bram_reg_responder_reg_file #(
        .DEPTH (DEPTH)
    ) u_rf (
        .aclk    (aclk),
        .areset  (areset),
        .i_we    (w_rf_we),
        .i_addr  (w_rf_addr),
        .i_wdata (w_rf_wdata),
        .o_rdata (w_rf_rdata)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_bram_rddata <= '0;
            r_host_rdata  <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (host_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    r_host_rdata <= w_rf_rdata;
                    r_state      <= ST_ACK;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Reads and writes both refresh the read register with the
            // pre-write word; a strobe while the host owns the array is
            // dropped and flagged.
            if (BRAM_en) begin
                if (w_host_sel) begin
                    r_bram_rddata <= OOR_DATA;
                    r_err         <= 1'b1;
                end else if (w_bram_oor) begin
                    r_bram_rddata <= OOR_DATA;
                end else begin
                    r_bram_rddata <= w_rf_rdata;
                end
            end
        end
    end

    assign BRAM_rddata   = r_bram_rddata;
    assign host_rdata    = r_host_rdata;
    assign BRAM_busy     = (r_state != ST_IDLE);
    assign host_ack      = (r_state == ST_ACK);
    assign err_collision = r_err;

endmodule
